// File: rtl/uart_tx_queue_pkg.sv
// uart_tx_queue_pkg
//   Shared definitions for the UART transmit queue:
//   - state_t      : drain FSM state encoding (IDLE, START, SEND)
//   - DEFAULT_*    : default queue depth, pointer width and start timeout
//   - cnt_width()  : width of a counter that must reach n-1
package uart_tx_queue_pkg;

  localparam int DEFAULT_DEPTH         = 16;
  localparam int DEFAULT_AW            = 4;
  localparam int DEFAULT_START_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo_8.sv
// sync_fifo_8
//   Byte-wide circular buffer with a level counter.
//   Ports:
//     clk      in   system clock
//     rst      in   asynchronous active-low reset
//     push     in   write wr_data (ignored while full)
//     pop      in   discard the head entry (ignored while empty)
//     wr_data  in   byte to store
//     rd_data  out  head entry (valid while empty=0)
//     full     out  DEPTH entries held
//     empty    out  no entries held
//     level    out  entry count, 0..DEPTH
//     drop     out  a push was attempted while full this cycle
module sync_fifo_8 #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          drop
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  // Fullness is judged before this edge's pop, so a push at full is
  // rejected even when a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign drop    = push && full;
  assign rd_data = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Byte queue feeding a UART transmitter through its transmit/tx_byte/busy
//   handshake. Producers push freely; a drain FSM forwards one byte at a time.
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous active-low reset
//     wr_en      in   push wr_data
//     wr_data    in   byte to queue
//     full       out  queue holds DEPTH entries
//     empty      out  queue holds no entries
//     level      out  entry count, 0..DEPTH
//     overflow   out  sticky: push attempted while full
//     start_err  out  sticky: busy never rose after a transmit pulse
//     clr_err    in   clear overflow and start_err
//     transmit   out  one-cycle start pulse to the UART
//     tx_byte    out  byte for the UART, held from transmit until busy falls
//     busy       in   UART transmitter busy
//     drain_irq  out  one-cycle pulse when the final queued byte completes
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int AW            = DEFAULT_AW,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          start_err,
  input  logic          clr_err,
  output logic          transmit,
  output logic [7:0]    tx_byte,
  input  logic          busy,
  output logic          drain_irq
);

  localparam int CW = cnt_width(START_TIMEOUT);

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            transmit_reg;
  logic [7:0]      tx_byte_reg;
  logic            drain_irq_reg;
  logic            overflow_reg;
  logic            start_err_reg;

  logic            fifo_empty;
  logic [7:0]      fifo_head;
  logic            fifo_drop;
  logic            pop;
  logic            start_timeout;

  // The FSM consumes the head whenever it is idle and data is waiting.
  assign pop = (state_reg == IDLE) && !fifo_empty;

  // The counter runs 0..START_TIMEOUT-1 over successive START cycles, so the
  // error flag appears START_TIMEOUT cycles after transmit went high.
  assign start_timeout = (state_reg == START) && !busy &&
                         (cnt_reg == CW'(START_TIMEOUT - 1));

  sync_fifo_8 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (fifo_empty),
    .level   (level),
    .drop    (fifo_drop)
  );

  // Drain FSM. busy is deliberately not consulted in IDLE: a stale busy
  // level must not stall the queue, and START re-checks it after the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      transmit_reg  <= 1'b0;
      tx_byte_reg   <= 8'h00;
      drain_irq_reg <= 1'b0;
    end else begin
      transmit_reg  <= 1'b0;
      drain_irq_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            tx_byte_reg  <= fifo_head;
            transmit_reg <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= START;
          end
        end
        START: begin
          if (busy) begin
            state_reg <= SEND;
          end else if (start_timeout) begin
            // Byte is abandoned, not retried.
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SEND: begin
          if (!busy) begin
            state_reg <= IDLE;
            if (fifo_empty) begin
              drain_irq_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg  <= 1'b0;
      start_err_reg <= 1'b0;
    end else begin
      if (fifo_drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_err) begin
        overflow_reg <= 1'b0;
      end
      if (start_timeout) begin
        start_err_reg <= 1'b1;
      end else if (clr_err) begin
        start_err_reg <= 1'b0;
      end
    end
  end

  assign empty     = fifo_empty;
  assign overflow  = overflow_reg;
  assign start_err = start_err_reg;
  assign transmit  = transmit_reg;
  assign tx_byte   = tx_byte_reg;
  assign drain_irq = drain_irq_reg;

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int ST       = 8;
  localparam int BUSY_LEN = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          start_err;
  logic          clr_err;
  logic          transmit;
  logic [7:0]    tx_byte;
  logic          busy;
  logic          drain_irq;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .DEPTH         (DEPTH),
    .AW            (AW),
    .START_TIMEOUT (ST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .start_err (start_err),
    .clr_err   (clr_err),
    .transmit  (transmit),
    .tx_byte   (tx_byte),
    .busy      (busy),
    .drain_irq (drain_irq)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         tx_cnt = 0;
  int         drain_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  int         peak = 0;
  logic       track = 1'b0;

  // busy source: 0 = UART model, 1 = forced high, 2 = forced low
  int         mode = 2;
  logic       tx_seen = 1'b0;
  logic       m_busy = 1'b0;
  int         m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  // Counts negedges from the current point until transmit is seen (bounded).
  task automatic wait_tx(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!transmit && k < 60);
  endtask

  task automatic wait_drain(input int target);
    for (int i = 0; i < 600 && drain_cnt < target; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    tick();
  endtask

  task automatic wait_empty_quiet();
    for (int i = 0; i < 600 && level != 0; i++) @(negedge clk);
    repeat (2 * ST + 4) @(negedge clk);
    tick();
  endtask

  // Simple UART stand-in: busy rises the cycle after a transmit pulse.
  always @(negedge clk) begin
    if (transmit) tx_seen = 1'b1;
  end

  always @(posedge clk) begin
    #2;
    if (mode == 0) begin
      if (tx_seen) begin
        m_busy  = 1'b1;
        m_cnt   = BUSY_LEN;
        tx_seen = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_busy = 1'b0;
      end
    end else begin
      tx_seen = 1'b0;
      m_busy  = 1'b0;
      m_cnt   = 0;
    end
    busy = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : m_busy;
  end

  // Monitor: every transmit pulse is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      last_byte = 8'h00;
    end else if (transmit) begin
      n_vec++;
      tx_cnt++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_tx: got %02h expected none", tx_byte);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_byte !== e) begin
          n_err++;
          $display("FAIL tx_byte: got %02h expected %02h", tx_byte, e);
        end else begin
          $display("tx byte %02h ok", tx_byte);
        end
      end
      last_byte = tx_byte;
    end else if (busy) begin
      n_vec++;
      if (tx_byte !== last_byte) begin
        n_err++;
        $display("FAIL tx_byte_hold: got %02h expected %02h", tx_byte, last_byte);
      end
    end
    if (rst && drain_irq) drain_cnt++;
    if (track && int'(level) > peak) peak = int'(level);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    int t0;

    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0; busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_transmit", transmit, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_overflow", overflow, 0);
    chk("rst_start_err", start_err, 0);
    chk("rst_drain_irq", drain_irq, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Single byte: transmit two cycles after the push, one drain_irq.
    mode = 0;
    tick();
    d0 = drain_cnt;
    exp_q.push_back(8'h41);
    push(8'h41);
    wait_tx(k);
    chk("single_latency", k, 2);
    wait_drain(d0 + 1);
    chk("single_drain", drain_cnt, d0 + 1);

    // Burst of three: one byte leaves immediately, so level peaks at 2.
    d0 = drain_cnt;
    t0 = tx_cnt;
    peak = 0;
    track = 1'b1;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    push(8'h41); push(8'h42); push(8'h43);
    repeat (3) tick();
    track = 1'b0;
    chk("burst_peak", peak, 2);
    wait_drain(d0 + 1);
    chk("burst_drain", drain_cnt, d0 + 1);
    chk("burst_count", tx_cnt - t0, 3);

    // Overflow with busy held high. 0x00 is popped into the FSM at once,
    // so 0x01..0x10 fill the 16 slots and only 0x11 is dropped.
    mode = 1;
    tick();
    d0 = drain_cnt;
    for (int b = 0; b < 18; b++) begin
      if (b <= 16) exp_q.push_back(8'(b));
      push(8'(b));
    end
    @(negedge clk);
    chk("ovf_full", full, 1);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    tick();
    clr_err = 1'b1;
    push(8'hEE);
    clr_err = 1'b0;
    @(negedge clk);
    chk("ovf_clr_collide", overflow, 1);
    chk("ovf_level_hold", level, 16);
    tick();
    mode = 0;
    wait_drain(d0 + 1);
    chk("ovf_drain", drain_cnt, d0 + 1);
    chk("ovf_empty", empty, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", overflow, 0);
    tick();

    // Start timeout with busy tied low.
    mode = 2;
    tick();
    d0 = drain_cnt;
    exp_q.push_back(8'h55);
    push(8'h55);
    wait_tx(k);
    chk("to_latency", k, 2);
    k = 0;
    while (start_err !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", k, ST);
    tick();
    exp_q.push_back(8'h66);
    push(8'h66);
    wait_tx(k);
    chk("to_retx_latency", k, 2);
    repeat (ST + 4) tick();
    chk("to_no_drain", drain_cnt, d0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    chk("to_cleared", start_err, 0);
    tick();

    // Push on the same edge the FSM pops, at level DEPTH-1.
    mode = 1;
    tick();
    for (int b = 0; b < 16; b++) begin
      exp_q.push_back(8'h80 + 8'(b));
      push(8'h80 + 8'(b));
    end
    @(negedge clk);
    chk("sim_level_pre", level, DEPTH - 1);
    tick();
    mode = 2;
    tick();                       // SEND sees busy low and returns to IDLE
    exp_q.push_back(8'h90);
    push(8'h90);                  // sampled on the edge IDLE pops
    @(negedge clk);
    chk("sim_level", level, DEPTH - 1);
    chk("sim_overflow", overflow, 0);
    chk("sim_transmit", transmit, 1);
    tick();
    wait_empty_quiet();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Reset mid-stream: queue and in-flight byte are discarded.
    mode = 1;
    tick();
    exp_q.push_back(8'hA0);
    for (int b = 0; b < 5; b++) push(8'hA0 + 8'(b));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_transmit", transmit, 0);
    chk("mid_rst_tx_byte", tx_byte, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    mode = 0;
    t0 = tx_cnt;
    repeat (40) tick();
    chk("mid_rst_no_tx", tx_cnt, t0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
